bcd_to_binary: RTL and testbench

Sequential converter from five packed BCD digits to a 16-bit unsigned binary value. It is the inverse of the calculator's binary-to-BCD path. Keypad or display-side decimal entries are turned into operands for the arithmetic unit. The block uses reverse double-dabble (shift right, subtract 3 from any digit ≥ 8), one bit per clock. It flags non-decimal digits and values that do not fit in 16 bits.

---
 rtl/bcd_to_binary_if.sv | 41 ++++
 rtl/bcd_to_binary.sv | 149 ++++++++++++++
 tb/tb_bcd_to_binary.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_if.sv
// Request/result bundle between a decimal-entry requester and bcd_to_binary.
// Latency: n/a (wires only).
// Backpressure: none; the requester watches busy and drops start once busy rises.
//
// Signals:
//   start           requester -> converter  request, sampled only while idle
//   bcd_input[19:0] requester -> converter  five packed BCD digits, [19:16] most significant
//   binary_output   converter -> requester  16-bit result, held until the next result
//   conversion_done converter -> requester  one-cycle pulse when results update
//   busy            converter -> requester  conversion in progress
//   overflow        converter -> requester  decimal value exceeded 65535 (result saturated)
//   invalid_digit   converter -> requester  some input nibble was above 9
interface bcd_to_binary_if;
  logic        start;
  logic [19:0] bcd_input;
  logic [15:0] binary_output;
  logic        conversion_done;
  logic        busy;
  logic        overflow;
  logic        invalid_digit;

  modport master (
    output start,
    output bcd_input,
    input  binary_output,
    input  conversion_done,
    input  busy,
    input  overflow,
    input  invalid_digit
  );

  modport slave (
    input  start,
    input  bcd_input,
    output binary_output,
    output conversion_done,
    output busy,
    output overflow,
    output invalid_digit
  );
endinterface

// File: rtl/bcd_to_binary.sv
// Five-digit BCD to 16-bit binary converter using reverse double-dabble, one bit per clock.
// Latency: 18 edges from the accepting edge to the result edge (1 edge for invalid digits), 19-cycle repeat.
// Backpressure: none; start is ignored while busy, the requester holds or drops start as it likes.
//
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset; aborts any conversion, clears every register
//   bus    bcd_to_binary_if.slave: start/bcd_input in; binary_output, conversion_done,
//          busy, overflow, invalid_digit out (all registered)
module bcd_to_binary (
  input  logic           clk_i,
  input  logic           rst_i,
  bcd_to_binary_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  // {bcd digits [36:17], binary accumulator [16:0]}
  logic [36:0] work_q, work_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        invalid_q, invalid_d;

  logic [15:0] bin_q, bin_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;
  logic        inv_q, inv_d;

  logic        in_invalid;
  logic [36:0] shifted;
  logic [36:0] adjusted;

  // Any nibble of the offered entry above 9 makes the whole entry invalid.
  always_comb begin
    in_invalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.bcd_input[4*i +: 4] > 4'd9) begin
        in_invalid = 1'b1;
      end
    end
  end

  // One reverse double-dabble step: shift right, then pull 3 back out of any
  // digit that reached 8 or more (the inverse of the forward "add 3 if >= 5").
  always_comb begin
    shifted  = {1'b0, work_q[36:1]};
    adjusted = shifted;
    for (int i = 0; i < 5; i++) begin
      if (shifted[17 + 4*i + 3]) begin
        adjusted[17 + 4*i +: 4] = shifted[17 + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    invalid_d = invalid_q;
    bin_d     = bin_q;
    ovf_d     = ovf_q;
    inv_d     = inv_q;
    done_d    = 1'b0;
    busy_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d    = {bus.bcd_input, 17'b0};
          cnt_d     = 5'd0;
          invalid_d = in_invalid;
          busy_d    = 1'b1;
          state_d   = in_invalid ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        work_d = adjusted;
        cnt_d  = cnt_q + 5'd1;
        busy_d = 1'b1;
        // cnt_q == 16 is the 17th shift; the accumulator is complete after this edge.
        if (cnt_q == 5'd16) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // busy stays up through the result edge and falls on the following one.
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
        if (invalid_q) begin
          bin_d = 16'h0000;
          ovf_d = 1'b0;
          inv_d = 1'b1;
        end else if (work_q[16]) begin
          // Accumulator tops out at 99999, so bit 16 alone means > 65535.
          bin_d = 16'hFFFF;
          ovf_d = 1'b1;
          inv_d = 1'b0;
        end else begin
          bin_d = work_q[15:0];
          ovf_d = 1'b0;
          inv_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      invalid_q <= 1'b0;
      bin_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      invalid_q <= invalid_d;
      bin_q     <= bin_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      inv_q     <= inv_d;
    end
  end

  assign bus.binary_output   = bin_q;
  assign bus.conversion_done = done_q;
  assign bus.busy            = busy_q;
  assign bus.overflow        = ovf_q;
  assign bus.invalid_digit   = inv_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: table of directed conversions plus
// hand-written sequences for start pulses, mid-conversion reset and back-to-back starts.
// Inputs are driven and outputs sampled on the falling edge.
module tb_bcd_to_binary;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bcd_to_binary_if bus ();

  bcd_to_binary dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] bcd;
    logic [15:0] bin;
    logic        ovf;
    logic        inv;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string name, input logic [15:0] eb,
                                  input logic eo, input logic ei);
    chk({name, " binary_output"},   {16'h0, bus.binary_output}, {16'h0, eb});
    chk({name, " conversion_done"}, {31'h0, bus.conversion_done}, 32'd0);
    chk({name, " busy"},            {31'h0, bus.busy}, 32'd0);
    chk({name, " overflow"},        {31'h0, bus.overflow}, {31'h0, eo});
    chk({name, " invalid_digit"},   {31'h0, bus.invalid_digit}, {31'h0, ei});
  endtask

  // One conversion with a one-cycle start pulse; checks latency, results,
  // and that the block returns to idle on the following edge.
  task automatic run_conv(input string name, input logic [19:0] bcd, input logic [15:0] eb,
                          input logic eo, input logic ei, input int lat);
    int  k;
    bit  seen;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.bcd_input = bcd;
    @(negedge clk);                 // after E0
    bus.start     = 1'b0;
    bus.bcd_input = 20'hFFFFF;      // later input changes must not matter
    chk({name, " busy after accept"}, {31'h0, bus.busy}, 32'd1);
    chk({name, " no done at E0"}, {31'h0, bus.conversion_done}, 32'd0);
    seen = 1'b0;
    k    = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);               // after E_i
      if (bus.conversion_done) begin
        seen = 1'b1;
        k    = i;
      end
    end
    if (!seen) begin
      chk({name, " done timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, " done edge"}, k, lat);
      chk({name, " busy with done"}, {31'h0, bus.busy}, 32'd1);
      chk({name, " binary_output"}, {16'h0, bus.binary_output}, {16'h0, eb});
      chk({name, " overflow"}, {31'h0, bus.overflow}, {31'h0, eo});
      chk({name, " invalid_digit"}, {31'h0, bus.invalid_digit}, {31'h0, ei});
      @(negedge clk);
      chk_idle_outputs({name, " after done"}, eb, eo, ei);
    end
  endtask

  vec_t vecs[12];
  int   pulses;
  int   first_idx;
  int   idxs[3];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{20'h12345, 16'h3039, 1'b0, 1'b0};
    vecs[1]  = '{20'h30577, 16'h7771, 1'b0, 1'b0};
    vecs[2]  = '{20'h00000, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{20'h65535, 16'hFFFF, 1'b0, 1'b0};
    vecs[4]  = '{20'h65536, 16'hFFFF, 1'b1, 1'b0};
    vecs[5]  = '{20'h1A345, 16'h0000, 1'b0, 1'b1};
    vecs[6]  = '{20'h09999, 16'h270F, 1'b0, 1'b0};
    vecs[7]  = '{20'h0000A, 16'h0000, 1'b0, 1'b1};
    vecs[8]  = '{20'h10000, 16'h2710, 1'b0, 1'b0};
    vecs[9]  = '{20'hA0000, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{20'h00009, 16'h0009, 1'b0, 1'b0};
    vecs[11] = '{20'h99999, 16'hFFFF, 1'b1, 1'b0};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.bcd_input = 20'h0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Two-cycle start pulse: exactly one conversion.
    bus.start     = 1'b1;
    bus.bcd_input = 20'h12345;
    pulses    = 0;
    first_idx = -1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);               // after E_i
      if (i == 1) bus.start = 1'b0;
      if (bus.conversion_done) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
      if (i >= 19) chk("2cyc busy idle", {31'h0, bus.busy}, 32'd0);
    end
    chk("2cyc pulses", pulses, 1);
    chk("2cyc done edge", first_idx, 18);
    chk("2cyc binary_output", {16'h0, bus.binary_output}, 32'h3039);

    // Table-driven conversions; vecs[11] (99999) leaves non-zero outputs for the reset test.
    for (int v = 0; v < 12; v++) begin
      run_conv($sformatf("vec%0d", v), vecs[v].bcd, vecs[v].bin, vecs[v].ovf, vecs[v].inv,
               vecs[v].inv ? 1 : 18);
    end

    // Reset at E9 of a conversion.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.bcd_input = 20'h12345;
    @(negedge clk);                 // after E0
    bus.start = 1'b0;
    repeat (8) @(negedge clk);      // after E8
    @(posedge clk);                 // E9
    #1 rst = 1'b1;
    #1 chk_idle_outputs("midreset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.conversion_done || bus.busy) pulses++;
    end
    chk("midreset no activity", pulses, 0);
    run_conv("after reset", 20'h00042, 16'h002A, 1'b0, 1'b0, 18);

    // bcd_input change and start pulse during SHIFT are ignored.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.bcd_input = 20'h12345;
    pulses    = 0;
    first_idx = -1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 5) begin
        bus.start     = 1'b1;
        bus.bcd_input = 20'h99999;
      end
      if (bus.conversion_done) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
    chk("shift-start pulses", pulses, 1);
    chk("shift-start done edge", first_idx, 18);
    chk("shift-start binary_output", {16'h0, bus.binary_output}, 32'h3039);
    chk("shift-start overflow", {31'h0, bus.overflow}, 32'd0);

    // start held high: a result every 19 cycles.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.bcd_input = 20'h00042;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.conversion_done) begin
        if (pulses < 3) idxs[pulses] = i;
        pulses++;
        chk("b2b binary_output", {16'h0, bus.binary_output}, 32'h002A);
      end
    end
    bus.start = 1'b0;
    chk("b2b pulses", pulses, 3);
    if (pulses == 3) begin
      chk("b2b first", idxs[0], 18);
      chk("b2b period1", idxs[1] - idxs[0], 19);
      chk("b2b period2", idxs[2] - idxs[1], 19);
    end
    repeat (25) @(negedge clk);
    chk("b2b final busy", {31'h0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
